// File: rtl/cpu_types_pkg.sv
// Shared types for the five-stage MIPS datapath: register-field width and
// the hazard unit's FSM state encoding.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DDONE = 2'd1,
    HALT  = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Cleared asynchronously by the active-low i_clr_n.
module sat_counter32 (
  input  logic        i_clk,
  input  logic        i_clr_n,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;
  logic        w_full;

  assign w_full  = (r_count == 32'hFFFF_FFFF);
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_count <= 32'd0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline latch enable/flush generation for the five-stage MIPS core.
// Optional stall/flush performance counters are built with HAZARD_PERF_EN.
module hazard_unit
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     dmemREN_MEM,
  input  logic     dmemWEN_MEM,
  input  logic     branch_MEM,
  input  logic     bne_MEM,
  input  logic     zero_MEM,
  input  logic     jump_MEM,
  input  logic     memtoReg_EX,
  input  logic     RegWr_EX,
  input  regbits_t wsel_EX,
  input  regbits_t rs_ID,
  input  regbits_t rt_ID,
  input  logic     halt_WB,
  output logic     pc_en,
  output logic     redirect,
  output logic     ifid_en,
  output logic     idex_en,
  output logic     exmem_en,
  output logic     memwb_en,
  output logic     ifid_flush,
  output logic     idex_flush,
  output logic     exmem_flush,
  output logic     dmem_mask,
  output logic     halt
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  hazard_state_t r_state;
  hazard_state_t w_next;

  logic w_dreq;
  logic w_mem_ok;
  logic w_advance;
  logic w_taken;
  logic w_lu;

  // DDONE means the data access already completed; fetch is the only holdout,
  // so the MEM request is masked and treated as satisfied.
  assign dmem_mask = (r_state == DDONE);
  assign halt      = (r_state == HALT);

  assign w_dreq    = (dmemREN_MEM | dmemWEN_MEM) & ~dmem_mask;
  assign w_mem_ok  = ~w_dreq | dhit | (r_state == DDONE);
  assign w_advance = ihit & w_mem_ok & (r_state != HALT);
  assign w_taken   = jump_MEM | (branch_MEM & (zero_MEM ^ bne_MEM));
  assign w_lu      = memtoReg_EX & RegWr_EX & (wsel_EX != '0) &
                     ((wsel_EX == rs_ID) | (wsel_EX == rt_ID));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN: begin
        if (halt_WB) begin
          w_next = HALT;
        end else if ((dmemREN_MEM | dmemWEN_MEM) & dhit & ~ihit) begin
          w_next = DDONE;
        end
      end
      DDONE: begin
        if (halt_WB) begin
          w_next = HALT;
        end else if (ihit) begin
          w_next = RUN;
        end
      end
      HALT:    w_next = HALT;
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    redirect    = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (w_advance) begin
      if (w_taken) begin
        // The load-use victim sits in a squashed slot, so the redirect wins.
        pc_en       = 1'b1;
        redirect    = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (w_lu) begin
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end else begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = (r_state != HALT) & (~w_advance | w_lu);
  assign w_flush_inc = w_advance & w_taken;

  sat_counter32 u_stall_cnt (
    .i_clk   (CLK),
    .i_clr_n (nRST),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

  sat_counter32 u_flush_cnt (
    .i_clk   (CLK),
    .i_clr_n (nRST),
    .i_inc   (w_flush_inc),
    .o_count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a combinational vector table in RUN plus
// hand-written multi-cycle sequences for DDONE, HALT and reset.
module tb_hazard_unit;
  import cpu_types_pkg::*;

  logic     CLK;
  logic     nRST;
  logic     ihit, dhit, dmemREN_MEM, dmemWEN_MEM;
  logic     branch_MEM, bne_MEM, zero_MEM, jump_MEM;
  logic     memtoReg_EX, RegWr_EX;
  regbits_t wsel_EX, rs_ID, rt_ID;
  logic     halt_WB;
  logic     pc_en, redirect, ifid_en, idex_en, exmem_en, memwb_en;
  logic     ifid_flush, idex_flush, exmem_flush, dmem_mask, halt;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hazard_unit dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .dmemREN_MEM (dmemREN_MEM),
    .dmemWEN_MEM (dmemWEN_MEM),
    .branch_MEM  (branch_MEM),
    .bne_MEM     (bne_MEM),
    .zero_MEM    (zero_MEM),
    .jump_MEM    (jump_MEM),
    .memtoReg_EX (memtoReg_EX),
    .RegWr_EX    (RegWr_EX),
    .wsel_EX     (wsel_EX),
    .rs_ID       (rs_ID),
    .rt_ID       (rt_ID),
    .halt_WB     (halt_WB),
    .pc_en       (pc_en),
    .redirect    (redirect),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .dmem_mask   (dmem_mask),
    .halt        (halt)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output bundle: {pc_en, redirect, ifid/idex/exmem/memwb_en,
  //                 ifid/idex/exmem_flush, dmem_mask, halt}
  logic [10:0] w_out;
  assign w_out = {pc_en, redirect, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, dmem_mask, halt};

  localparam logic [10:0] E_RUN      = 11'b1_0_1111_000_0_0;
  localparam logic [10:0] E_STALL    = 11'b0_0_0000_000_0_0;
  localparam logic [10:0] E_LU       = 11'b0_0_0111_010_0_0;
  localparam logic [10:0] E_TAKEN    = 11'b1_1_1111_111_0_0;
  localparam logic [10:0] E_DD_STALL = 11'b0_0_0000_000_1_0;
  localparam logic [10:0] E_DD_RUN   = 11'b1_0_1111_000_1_0;
  localparam logic [10:0] E_HALT     = 11'b0_0_0000_000_0_1;

  typedef struct {
    string       name;
    logic        ihit, dhit, ren, wen;
    logic        br, bne, zero, jmp;
    logic        m2r, rwr;
    logic [4:0]  wsel, rs, rt;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[15];

  // Driver tasks
  task automatic set_idle(input logic ih);
    ihit = ih; dhit = 1'b0; dmemREN_MEM = 1'b0; dmemWEN_MEM = 1'b0;
    branch_MEM = 1'b0; bne_MEM = 1'b0; zero_MEM = 1'b0; jump_MEM = 1'b0;
    memtoReg_EX = 1'b0; RegWr_EX = 1'b0;
    wsel_EX = '0; rs_ID = '0; rt_ID = '0; halt_WB = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    ihit = v.ihit; dhit = v.dhit; dmemREN_MEM = v.ren; dmemWEN_MEM = v.wen;
    branch_MEM = v.br; bne_MEM = v.bne; zero_MEM = v.zero; jump_MEM = v.jmp;
    memtoReg_EX = v.m2r; RegWr_EX = v.rwr;
    wsel_EX = v.wsel; rs_ID = v.rs; rt_ID = v.rt; halt_WB = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    set_idle(1'b0);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //          name          ih dh rn wn br bn zr jp m2 rw wsel rs  rt  exp
    vecs[0]  = '{"idle_hit",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, E_RUN};
    vecs[1]  = '{"imiss",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, E_STALL};
    vecs[2]  = '{"lu_rs",      1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5,  5,  0, E_LU};
    vecs[3]  = '{"lu_rt",      1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9,  3,  9, E_LU};
    vecs[4]  = '{"lu_r0",      1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0,  0, E_RUN};
    vecs[5]  = '{"lu_nowr",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5,  5,  5, E_RUN};
    vecs[6]  = '{"lu_nomatch", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5,  4,  6, E_RUN};
    vecs[7]  = '{"bne_taken",  1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 5,  5,  0, E_TAKEN};
    vecs[8]  = '{"bne_nt",     1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0,  0,  0, E_RUN};
    vecs[9]  = '{"beq_taken",  1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,  0,  0, E_TAKEN};
    vecs[10] = '{"jump",       1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0,  0, E_TAKEN};
    vecs[11] = '{"jump_imiss", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0,  0, E_STALL};
    vecs[12] = '{"ld_dmiss",   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, E_STALL};
    vecs[13] = '{"ld_hit",     1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, E_RUN};
    vecs[14] = '{"st_miss_br", 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 7,  7,  0, E_STALL};

    // Reset state: outputs follow RUN with no inputs asserted.
    set_idle(1'b0);
    nRST = 1'b0;
    #1;
    check("reset_outputs", 32'(w_out), 32'(E_STALL));
    @(negedge CLK);
    set_idle(1'b1);
    #1;
    check("reset_ihit_run", 32'(w_out), 32'(E_RUN));
`ifdef HAZARD_PERF_EN
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);
`endif
    @(negedge CLK);
    nRST = 1'b1;

    // Table: every vector keeps the FSM in RUN.
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      apply_vec(vecs[i]);
      #1;
      check(vecs[i].name, 32'(w_out), 32'(vecs[i].exp));
    end

    // Split hits: data completes while fetch misses -> DDONE, masked request.
    reset_pulse();
    set_idle(1'b0);
    dmemREN_MEM = 1'b1; dhit = 1'b1;
    #1;
    check("split_first", 32'(w_out), 32'(E_STALL));
    next_cycle();
    dhit = 1'b0;
    #1;
    check("split_ddone1", 32'(w_out), 32'(E_DD_STALL));
    next_cycle();
    #1;
    check("split_ddone2", 32'(w_out), 32'(E_DD_STALL));
    ihit = 1'b1;
    #1;
    check("split_release", 32'(w_out), 32'(E_DD_RUN));
    next_cycle();
    dmemREN_MEM = 1'b0;
    #1;
    check("split_back_run", 32'(w_out), 32'(E_RUN));

    // Data miss on a store: four frozen cycles, then advance on dhit.
    reset_pulse();
    set_idle(1'b1);
    dmemWEN_MEM = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("dmiss_stall%0d", c), 32'(w_out), 32'(E_STALL));
      next_cycle();
    end
    dhit = 1'b1;
    #1;
    check("dmiss_hit", 32'(w_out), 32'(E_RUN));
`ifdef HAZARD_PERF_EN
    check("dmiss_stall_cnt", stall_cnt, 32'd4);
`endif

    // Load-use bubble lasts one cycle; next cycle the load is in MEM.
    @(negedge CLK);
    set_idle(1'b1);
    memtoReg_EX = 1'b1; RegWr_EX = 1'b1; wsel_EX = 5'd5; rs_ID = 5'd5;
    #1;
    check("lu_bubble", 32'(w_out), 32'(E_LU));
    next_cycle();
    memtoReg_EX = 1'b0; RegWr_EX = 1'b0; wsel_EX = 5'd0;
    dmemREN_MEM = 1'b1; dhit = 1'b1;
    #1;
    check("lu_after", 32'(w_out), 32'(E_RUN));

    // Taken bne overriding load-use counts one flush.
    reset_pulse();
    set_idle(1'b1);
    branch_MEM = 1'b1; bne_MEM = 1'b1;
    memtoReg_EX = 1'b1; RegWr_EX = 1'b1; wsel_EX = 5'd5; rs_ID = 5'd5;
    #1;
    check("bne_lu_taken", 32'(w_out), 32'(E_TAKEN));
    next_cycle();
    set_idle(1'b1);
    #1;
    check("bne_after", 32'(w_out), 32'(E_RUN));
`ifdef HAZARD_PERF_EN
    check("bne_flush_cnt", flush_cnt, 32'd1);
`endif

    // Halt from DDONE is sticky until reset.
    reset_pulse();
    set_idle(1'b0);
    dmemREN_MEM = 1'b1; dhit = 1'b1;
    next_cycle();
    dhit = 1'b0;
    halt_WB = 1'b1;
    #1;
    check("halt_in_ddone", 32'(w_out), 32'(E_DD_STALL));
    next_cycle();
    set_idle(1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("halt_hold%0d", c), 32'(w_out), 32'(E_HALT));
      next_cycle();
    end
    reset_pulse();
    set_idle(1'b1);
    #1;
    check("halt_cleared", 32'(w_out), 32'(E_RUN));
`ifdef HAZARD_PERF_EN
    check("halt_stall_cnt", stall_cnt, 32'd0);
    check("halt_flush_cnt", flush_cnt, 32'd0);
`endif

    // Asynchronous reset mid-DDONE, between clock edges.
    @(negedge CLK);
    set_idle(1'b0);
    dmemREN_MEM = 1'b1; dhit = 1'b1;
    next_cycle();
    dhit = 1'b0;
    #1;
    check("arst_pre", 32'(w_out), 32'(E_DD_STALL));
    #1;
    nRST = 1'b0;
    #1;
    check("arst_mask", 32'(dmem_mask), 32'd0);
    set_idle(1'b1);
    #1;
    check("arst_run", 32'(w_out), 32'(E_RUN));
    @(negedge CLK);
    nRST = 1'b1;

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the five-stage MIPS datapath. It generates the enable/flush pair for every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It resolves three conditions: cache wait, load-use hazard, and control redirect resolved in MEM. It also holds a small FSM that remembers a completed data access while fetch is still stalled, and latches halt.

## Interface
- No parameters; widths come from `cpu_types_pkg`.
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `ihit` in 1: instruction cache hit this cycle.
- `dhit` in 1: data cache hit this cycle.
- `dmemREN_MEM`, `dmemWEN_MEM` in 1 each: MEM-stage load/store request, before masking.
- `branch_MEM` in 1: beq/bne in MEM.
- `bne_MEM` in 1: the branch is bne.
- `zero_MEM` in 1: ALU zero latched in EX/MEM.
- `jump_MEM` in 1: j/jal/jr in MEM.
- `memtoReg_EX` in 1: load in EX.
- `RegWr_EX` in 1: EX instruction writes a register.
- `wsel_EX` in 5: EX destination register.
- `rs_ID`, `rt_ID` in 5 each: source registers of the ID instruction.
- `halt_WB` in 1: halt instruction in WB.
- `pc_en` out 1: PC may load.
- `redirect` out 1: PC selects the MEM target.
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: latch enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1 each: latch flushes, effective on the same edge.
- `dmem_mask` out 1: suppress the MEM request.
- `halt` out 1: processor halted (sticky).
- `stall_cnt`, `flush_cnt` out 32 each: present only with `HAZARD_PERF_EN`.

## Operation
FSM states and transitions:
- RUN → DDONE on `(dmemREN_MEM|dmemWEN_MEM) & dhit & !ihit`.
- RUN → HALT on `halt_WB`.
- DDONE → RUN on `ihit`.
- DDONE → HALT on `halt_WB`.
- HALT: absorbing until `nRST`.

Combinational terms:
- `dreq = (dmemREN_MEM|dmemWEN_MEM) & !dmem_mask`.
- `dmem_mask = (state==DDONE)`.
- `mem_ok = !dreq | dhit | (state==DDONE)`.
- `advance = ihit & mem_ok & (state!=HALT)`.
- `taken = jump_MEM | (branch_MEM & (zero_MEM ^ bne_MEM))`.
- `lu = memtoReg_EX & RegWr_EX & (wsel_EX!=0) & (wsel_EX==rs_ID | wsel_EX==rt_ID)`.

Output priority, highest first:
- HALT: all enables 0, all flushes 0, `halt=1`.
- `!advance`: all enables 0, all flushes 0. The whole pipe freezes.
- `taken`:
  - All enables 1 and `redirect=1`.
  - `ifid_flush`, `idex_flush`, `exmem_flush` = 1.
  - The load-use condition is ignored, because the hazarding instruction is squashed.
- `lu`:
  - `pc_en=0`, `ifid_en=0`.
  - `idex_en=1` with `idex_flush=1`, inserting one bubble.
  - `exmem_en=1`, `memwb_en=1`.
- Otherwise: all enables 1, no flush.

Outputs are combinational from state plus inputs. Only the FSM state (and the counters) is registered.

## Timing
- Reset values: state RUN, `halt=0`, `dmem_mask=0`, counters 0.
  - During reset, combinational outputs follow RUN with no inputs asserted.
- Latency:
  - Flush and enable act on the same rising edge they are asserted for.
  - The load-use bubble costs exactly one cycle. On the next cycle the load sits in MEM, so `lu` deasserts.
  - A taken redirect costs three squashed slots.
- `dhit` and `ihit` both high in RUN: advance immediately, no DDONE entry.
- DDONE with `ihit` high: advance and return to RUN on the same edge. The MEM request is not re-issued.
- `halt_WB` while in DDONE: HALT wins.
- `nRST` low mid-operation: state returns to RUN asynchronously and the counters clear.

## Configuration
- `HAZARD_PERF_EN` defined: `stall_cnt` increments on every non-HALT cycle with `!advance | lu`, and `flush_cnt` on every advancing cycle with `taken`. Both saturate at 32'hFFFF_FFFF.
- `HAZARD_PERF_EN` undefined: ports and registers are absent, and control behaviour is identical.

## Structure
- Add `hazard_state_t` (RUN, DDONE, HALT; 2-bit enum) to `cpu_types_pkg`.
- `regbits_t` from the package types the 5-bit register fields.
- One sub-module, `sat_counter32`, with increment enable and asynchronous active-low clear. It is instantiated twice, only under `HAZARD_PERF_EN`.

## Test plan
- Load-use: `memtoReg_EX=1`, `RegWr_EX=1`, `wsel_EX=5`, `rs_ID=5`, caches hit → `pc_en=0`, `ifid_en=0`, `idex_flush=1` for one cycle. With `wsel_EX=0` → no stall.
- Taken bne: `branch_MEM=1`, `bne_MEM=1`, `zero_MEM=0`, with `lu` also true → `redirect=1`, three flushes, `pc_en=1`, `flush_cnt` +1. With `zero_MEM=1` → no redirect.
- Split hits: `dmemREN_MEM=1`, `dhit=1`, `ihit=0` → next cycle state DDONE, `dmem_mask=1`, all enables 0. `ihit=1` two cycles later → advance, state RUN.
- Data miss: `dmemWEN_MEM=1`, `dhit=0` for 4 cycles, `ihit=1` → enables 0 for 4 cycles, `stall_cnt=4`. Enables 1 on the `dhit` cycle.
- Halt: `halt_WB=1` for one cycle while in DDONE → `halt=1` and enables 0 indefinitely. After `nRST` pulse → `halt=0`, RUN, counters 0.
- Reset mid-stall: `nRST` low asynchronously during DDONE → immediate RUN, `dmem_mask=0`.
